// File: rtl/fx_addsub_pipe.sv
// Two-stage multi-lane fixed-point add/subtract with halving modes, saturate or wrap
// overflow policy, valid/ready backpressure and an overflow monitor.
module fx_addsub_pipe #(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int LANES = 2,
  parameter bit SAT   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] summand_1,
  input  logic [LANES*W-1:0] summand_2,
  input  logic [1:0]         add_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] res,
  output logic [LANES-1:0]   res_ovf,
  input  logic               clr_ovf,
  output logic               ovf_sticky,
  output logic [15:0]        ovf_count
);

  localparam int WE = W + 1;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  // N only labels the Q format; reject formats with no integer bits.
  if (N < 0 || N >= W) begin : g_bad_frac
    $error("fx_addsub_pipe: fractional bits must lie in [0, W-1]");
  end

  logic                  s1_valid_r;
  logic [LANES*WE-1:0]   s1_sum_r;
  logic                  s2_valid_r;
  logic [LANES*W-1:0]    res_r;
  logic [LANES-1:0]      res_ovf_r;
  logic                  ovf_sticky_r;
  logic [15:0]           ovf_count_r;

  logic                  s2_adv_s;
  logic                  s1_load_s;
  logic                  ovf_hs_s;
  logic [LANES*WE-1:0]   sum_s;
  logic [LANES*W-1:0]    cond_s;
  logic [LANES-1:0]      ovf_s;

  // Exact W+1 sum/difference; halving works in W+2 bits so the +1 cannot wrap.
  function automatic logic [W:0] stage1(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] mode);
    logic [W+1:0] ax, bx, full, rnd;
    ax = {{2{a[W-1]}}, a};
    bx = {{2{b[W-1]}}, b};
    if (mode[0]) full = ax - bx;
    else         full = ax + bx;
    rnd = full + {{(W+1){1'b0}}, 1'b1};
    if (mode[1]) stage1 = rnd[W+1:1];
    else         stage1 = full[W:0];
  endfunction

  // Returns {ovf, value}; halved values are already in range so never flag.
  function automatic logic [W:0] condition(input logic [W:0] v);
    logic ovf;
    ovf = (v[W] != v[W-1]);
    if (ovf && SAT) condition = {1'b1, (v[W] ? MAX_NEG : MAX_POS)};
    else            condition = {ovf, v[W-1:0]};
  endfunction

  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign s1_load_s = !s1_valid_r || s2_adv_s;
  assign in_ready  = rst_n && s1_load_s;

  // Per-lane arithmetic for S1 and overflow conditioning for S2.
  always_comb begin
    sum_s  = '0;
    cond_s = '0;
    ovf_s  = '0;
    for (int k = 0; k < LANES; k++) begin
      logic [W:0] c;
      sum_s[k*WE +: WE] = stage1(summand_1[k*W +: W], summand_2[k*W +: W], add_mode);
      c                 = condition(s1_sum_r[k*WE +: WE]);
      cond_s[k*W +: W]  = c[W-1:0];
      ovf_s[k]          = c[W];
    end
  end

  // S1 register: fills whenever it is empty or its beat moves into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sum_r   <= '0;
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) s1_sum_r <= sum_s;
    end
  end

  // S2 register: output beat, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      res_r      <= '0;
      res_ovf_r  <= '0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        res_r     <= cond_s;
        res_ovf_r <= ovf_s;
      end
    end
  end

  assign ovf_hs_s = s2_valid_r && out_ready && (|res_ovf_r);

  // Overflow monitor; a clear coinciding with an overflowing handshake counts that beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_r <= 1'b0;
      ovf_count_r  <= 16'd0;
    end else if (clr_ovf) begin
      ovf_sticky_r <= ovf_hs_s;
      ovf_count_r  <= {15'd0, ovf_hs_s};
    end else if (ovf_hs_s) begin
      ovf_sticky_r <= 1'b1;
      if (ovf_count_r != 16'hFFFF) ovf_count_r <= ovf_count_r + 16'd1;
    end
  end

  assign out_valid  = s2_valid_r;
  assign res        = res_r;
  assign res_ovf    = res_ovf_r;
  assign ovf_sticky = ovf_sticky_r;
  assign ovf_count  = ovf_count_r;

endmodule

// File: tb/tb_fx_addsub_pipe.sv
// Bench for fx_addsub_pipe: saturating and wrapping instances share stimulus and are
// checked against an integer reference model and an in-order scoreboard.
module tb_fx_addsub_pipe;
  localparam int W = 16;
  localparam int L = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            clr_ovf = 1'b0;
  logic [1:0]      add_mode = 2'd0;
  logic [L*W-1:0]  summand_1 = '0;
  logic [L*W-1:0]  summand_2 = '0;

  logic            in_ready, out_valid, ovf_sticky;
  logic [L*W-1:0]  res;
  logic [L-1:0]    res_ovf;
  logic [15:0]     ovf_count;
  logic            in_ready_w, out_valid_w, ovf_sticky_w;
  logic [L*W-1:0]  res_w;
  logic [L-1:0]    res_ovf_w;
  logic [15:0]     ovf_count_w;

  always #5 clk = ~clk;

  fx_addsub_pipe #(.W(W), .N(4), .LANES(L), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .summand_1(summand_1), .summand_2(summand_2), .add_mode(add_mode),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .res_ovf(res_ovf),
    .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count));

  fx_addsub_pipe #(.W(W), .N(4), .LANES(L), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .summand_1(summand_1), .summand_2(summand_2), .add_mode(add_mode),
    .out_valid(out_valid_w), .out_ready(out_ready), .res(res_w), .res_ovf(res_ovf_w),
    .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky_w), .ovf_count(ovf_count_w));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q_res[$];
  logic [31:0] q_resw[$];
  logic [1:0]  q_ovf[$];
  bit          m_sticky = 1'b0;
  int          m_count = 0;
  bit          held = 1'b0;
  logic [31:0] held_res = '0;
  bit          last_acc = 1'b0;

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: returns {ovf, 16-bit result}.
  function automatic logic [16:0] ref_lane(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] m, input bit sat);
    int sa, sb, r;
    logic [31:0] rv;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = m[0] ? sa - sb : sa + sb;
    if (m[1]) begin
      r  = (r + 1) >>> 1;
      rv = r;
      return {1'b0, rv[15:0]};
    end
    rv = r;
    if (r > 32767)  return sat ? {1'b1, 16'h7FFF} : {1'b1, rv[15:0]};
    if (r < -32768) return sat ? {1'b1, 16'h8000} : {1'b1, rv[15:0]};
    return {1'b0, rv[15:0]};
  endfunction

  function automatic logic [33:0] ref_beat(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] m, input bit sat);
    logic [16:0] l0, l1;
    l0 = ref_lane(a[15:0], b[15:0], m, sat);
    l1 = ref_lane(a[31:16], b[31:16], m, sat);
    return {l1[16], l0[16], l1[15:0], l0[15:0]};
  endfunction

  // One clock: entered just after a falling edge with inputs already driven.
  task automatic cycle();
    bit          hs, any_ovf;
    logic [33:0] r1, r0;
    #1;
    check(in_ready, !(q_res.size() == 2 && !out_ready), "in_ready");
    if (q_res.size() == 2) check(out_valid, 1'b1, "full_out_valid");
    if (q_res.size() == 0) check(out_valid, 1'b0, "spurious_out_valid");
    if (held) begin
      check(out_valid, 1'b1, "stall_valid");
      check(res, held_res, "stall_res");
    end
    held     = out_valid && !out_ready;
    held_res = res;
    hs       = out_valid && out_ready;
    any_ovf  = 1'b0;
    if (hs && q_res.size() != 0) begin
      check(res, q_res[0], "res");
      check(res_ovf, q_ovf[0], "res_ovf");
      check(res_w, q_resw[0], "res_wrap");
      check(res_ovf_w, q_ovf[0], "res_ovf_wrap");
      any_ovf = |q_ovf[0];
      void'(q_res.pop_front());
      void'(q_ovf.pop_front());
      void'(q_resw.pop_front());
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      r1 = ref_beat(summand_1, summand_2, add_mode, 1'b1);
      r0 = ref_beat(summand_1, summand_2, add_mode, 1'b0);
      q_res.push_back(r1[31:0]);
      q_ovf.push_back(r1[33:32]);
      q_resw.push_back(r0[31:0]);
    end
    if (clr_ovf) begin
      m_sticky = hs && any_ovf;
      m_count  = (hs && any_ovf) ? 1 : 0;
    end else if (hs && any_ovf) begin
      m_sticky = 1'b1;
      if (m_count != 65535) m_count++;
    end
    @(posedge clk);
    @(negedge clk);
    check(ovf_sticky, m_sticky, "ovf_sticky");
    check(ovf_count, m_count[15:0], "ovf_count");
  endtask

  // Single beat into an empty pipeline: checks the 2-cycle latency and the result.
  task automatic send_check(input logic [15:0] a0, input logic [15:0] b0,
                            input logic [15:0] a1, input logic [15:0] b1,
                            input logic [1:0] m, input logic [31:0] er,
                            input logic [1:0] eo, input logic [31:0] erw, input string tag);
    out_ready = 1'b1;
    summand_1 = {a1, a0};
    summand_2 = {b1, b0};
    add_mode  = m;
    in_valid  = 1'b1;
    cycle();
    check(last_acc, 1'b1, {tag, "_accept"});
    in_valid = 1'b0;
    check(out_valid, 1'b0, {tag, "_lat1"});
    cycle();
    check(out_valid, 1'b1, {tag, "_lat2"});
    check(res, er, {tag, "_res"});
    check(res_ovf, eo, {tag, "_ovf"});
    check(res_w, erw, {tag, "_res_wrap"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int budget;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check(in_ready, 1'b0, "rst_in_ready");
    check(out_valid, 1'b0, "rst_out_valid");
    check(res, 32'h0, "rst_res");
    check(res_ovf, 2'b00, "rst_res_ovf");
    check(ovf_sticky, 1'b0, "rst_sticky");
    check(ovf_count, 16'h0, "rst_count");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(in_ready, 1'b1, "release_in_ready");
    @(negedge clk);

    // Directed arithmetic cases
    send_check(16'hB61C, 16'h6627, 16'h0, 16'h0, 2'b00, 32'h00001C43, 2'b00, 32'h00001C43, "add");
    send_check(16'hB61C, 16'h6627, 16'h0, 16'h0, 2'b01, 32'h00008000, 2'b01, 32'h00004FF5, "sub_ovf");
    send_check(16'hB61C, 16'h6627, 16'h0, 16'h0, 2'b10, 32'h00000E22, 2'b00, 32'h00000E22, "half_add");
    send_check(16'hB61C, 16'h6627, 16'h0, 16'h0, 2'b11, 32'h0000A7FB, 2'b00, 32'h0000A7FB, "half_sub");
    send_check(16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 2'b10, 32'h00007FFF, 2'b00, 32'h00007FFF, "half_max");
    cycle();
    check(ovf_count, 16'd1, "count_after_sub");
    check(ovf_sticky, 1'b1, "sticky_after_sub");

    // Two lanes, overflow in lane 0 only; then the same with a coinciding clear
    send_check(16'h7FFF, 16'h0001, 16'h0001, 16'h0001, 2'b00, 32'h00027FFF, 2'b01, 32'h00028000, "lanes");
    cycle();
    check(ovf_count, 16'd2, "count_lanes");
    send_check(16'h7FFF, 16'h0001, 16'h0001, 16'h0001, 2'b00, 32'h00027FFF, 2'b01, 32'h00028000, "lanes_clr");
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check(ovf_sticky, 1'b1, "clr_same_sticky");
    check(ovf_count, 16'd1, "clr_same_count");

    // Random stream with random backpressure, mode changes and occasional clears
    sent   = 0;
    budget = 0;
    while ((sent < 40 || q_res.size() != 0) && budget < 2000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      if (sent < 40) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        summand_1 = $urandom();
        summand_2 = $urandom();
        add_mode  = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (last_acc) sent++;
      budget++;
    end
    clr_ovf = 1'b0;
    check(q_res.size(), 0, "stream_drained");

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    summand_1 = 32'h11112222;
    summand_2 = 32'h33334444;
    add_mode  = 2'b00;
    cycle();
    cycle();
    in_valid = 1'b0;
    #1;
    check(in_ready, 1'b0, "full_in_ready");
    #1;
    rst_n = 1'b0;
    #1;
    check(out_valid, 1'b0, "midrst_out_valid");
    check(in_ready, 1'b0, "midrst_in_ready");
    check(ovf_count, 16'h0, "midrst_count");
    check(ovf_sticky, 1'b0, "midrst_sticky");
    q_res.delete();
    q_ovf.delete();
    q_resw.delete();
    m_sticky = 1'b0;
    m_count  = 0;
    held     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();
    send_check(16'h1234, 16'h0101, 16'h8000, 16'h0001, 2'b01, 32'h80001133, 2'b10, 32'h7FFF1133, "post_rst");
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fx_addsub_pipe.md
# fx_addsub_pipe

Parametrised, pipelined fixed-point add/subtract unit for the FFT datapath. It is the streaming successor of the combinational `adder` and supports multiple lanes (e.g. re/im), four arithmetic modes including halving for per-stage FFT scaling, and saturate/wrap overflow policy. It adds valid/ready flow control with backpressure and overflow monitoring, and sits between butterfly stages.

## Interface
- `W`, 16, lane width in bits (two's complement, Qx.N)
- `N`, 4, fractional bits; informational only, arithmetic is format-agnostic
- `LANES`, 2, independent lanes per beat
- `SAT`, 1, 1 = saturate on overflow, 0 = wrap
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: input beat valid
- `in_ready` out 1: input accepted when `in_valid && in_ready`
- `summand_1` in LANES*W: operand A, lane k at bits [k*W +: W]
- `summand_2` in LANES*W: operand B, same packing
- `add_mode` in 2: 00 A+B, 01 A−B, 10 (A+B)/2, 11 (A−B)/2; sampled with the beat
- `out_valid` out 1: result beat valid
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`
- `res` out LANES*W: result, same packing
- `res_ovf` out LANES: per-lane overflow flag of the current output beat
- `clr_ovf` in 1: synchronous clear of `ovf_sticky`/`ovf_count`
- `ovf_sticky` out 1: set once any accepted output beat had overflow
- `ovf_count` out 16: number of accepted output beats with any overflow; saturates at 0xFFFF

## Operation
- Two register stages, S1 and S2, each with its own valid bit.
- S1 (compute): sign-extend A and B to W+1 bits and add or subtract. The W+1-bit result is exact. For halving modes, register (sum+1)>>>1, which is round-half-up.
- S2 (condition): in full modes, overflow means the W+1 result is outside [−2^(W−1), 2^(W−1)−1].
  - SAT=1: clamp to 0x7FFF or 0x8000 (W=16).
  - SAT=0: keep the low W bits.
  - `res_ovf[k]`=1 on overflow in either policy.
- Halving modes never overflow; `res_ovf`=0.
- Lanes are fully independent and share only `add_mode`.
- Flow control:
  - S2 advances when `!s2_valid || out_ready`.
  - S1 advances when S2 advances or `!s2_valid`.
  - `in_ready` = rst_n && (`!s1_valid || s1 advances`). This is combinational from `out_ready`.
- Data is held stable while `out_valid && !out_ready`.
- Monitor: on each output handshake whose beat has any `res_ovf` bit set, set `ovf_sticky` and increment `ovf_count` (saturating).
  - `clr_ovf` clears both.
  - If `clr_ovf` and an overflowing handshake occur in the same cycle, the result is sticky=1, count=1.

## Timing
- Reset (async assert, sync-safe deassert): `out_valid`=0, `res`=0, `res_ovf`=0, `ovf_sticky`=0, `ovf_count`=0, both stage valids=0. `in_ready`=0 while `rst_n` low and 1 in the first cycle after release.
- Latency: a beat accepted at edge t is presented on `out_valid`/`res` after edge t+2 when there is no backpressure.
- Throughput: 1 beat/cycle sustained with `out_ready`=1.
- Full pipeline (both stages valid) with `out_ready`=0: `in_ready`=0, no beat is lost or duplicated.
- Stall release: in the cycle `out_ready` rises, `in_ready`=1 and one beat may enter while one leaves.
- Reset mid-stream: all in-flight beats are discarded; no output handshake follows until new input.
- `add_mode` is per-beat: mode changes on consecutive beats take effect without bubbles.

## Test plan
- W=16, LANES=1, SAT=1, A=0xB61C, B=0x6627, mode 00 -> `res`=0x1C43, `res_ovf`=0, `out_valid` 2 cycles after accept.
- Same operands, mode 01: SAT=1 -> `res`=0x8000, `res_ovf`=1, `ovf_count`=1. SAT=0 -> `res`=0x4FF5, `res_ovf`=1.
- Same operands, mode 10 -> 0x0E22; mode 11 -> 0xA7FB; both with `res_ovf`=0. Also A=B=0x7FFF, mode 10 -> 0x7FFF.
- Stream 8 beats back-to-back with `out_ready` toggling randomly -> all 8 results in order, no drops or duplicates, `res` stable during stalls, `in_ready`=0 only when both stages are full.
- LANES=2, lane0 A=0x7FFF B=0x0001 mode 00, lane1 A=0x0001 B=0x0001 -> `res`={0x0002,0x7FFF}, `res_ovf`=2'b01. Repeat with `clr_ovf` pulsed on the same handshake -> `ovf_sticky`=1, `ovf_count`=1.
- Assert `rst_n` low with 2 beats in flight -> `out_valid` drops immediately, counters are 0, and after release the first output is the next accepted beat.
